// File: rtl/avg_power_db.sv
// Complex-sample power to Q8.8 dB back end.
// Five register stages: square, sum, window reduce, log2, dB scale.
module avg_power_db #(
    parameter int DW           = 18,
    parameter int AVG_LOG2_MAX = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic signed [DW-1:0] re_i,
    input  logic signed [DW-1:0] im_i,
    input  logic                 valid_i,
    input  logic [3:0]           avg_sel_i,
    input  logic                 mode_i,
    output logic [15:0]          db_o,
    output logic                 valid_o
);

    localparam int PW = 2 * DW;
    localparam int AW = PW + AVG_LOG2_MAX;
    localparam int CW = (AVG_LOG2_MAX > 0) ? AVG_LOG2_MAX : 1;
    localparam int IW = $clog2(PW);

    // S1 squares, window config travels with its sample
    logic              s1_vld_q;
    logic [PW-1:0]     s1_re2_q, s1_re2_d;
    logic [PW-1:0]     s1_im2_q, s1_im2_d;
    logic [3:0]        s1_n_q, s1_n_d;
    logic              s1_mode_q;
    logic signed [PW-1:0] re_sq, im_sq;

    // S2 power
    logic              s2_vld_q;
    logic [PW-1:0]     s2_p_q, s2_p_d;
    logic [3:0]        s2_n_q;
    logic              s2_mode_q;

    // S3 reducer
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [AW-1:0]     acc_q, acc_d;
    logic [3:0]        win_n_q, win_n_d;
    logic              win_mode_q, win_mode_d;
    logic              win_vld_q, win_vld_d;
    logic [PW-1:0]     win_q, win_d;
    logic              first, last, mode_eff;
    logic [3:0]        n_eff;
    logic [15:0]       last_cnt;
    logic [AW-1:0]     sum;
    logic [PW-1:0]     peak;

    // S4 log2
    logic              lg_vld_q;
    logic [15:0]       lg_q, lg_d;
    logic [IW-1:0]     k_c;
    logic [3:0]        f_c;
    logic [7:0]        frac_c;

    // S5 scale
    logic [39:0]       prod;
    logic [23:0]       db_wide;
    logic [15:0]       db_d;

    function automatic logic [7:0] log_lut(input logic [3:0] f);
        logic [7:0] v;
        v = 8'd0;
        unique case (f)
            4'd0:  v = 8'd0;
            4'd1:  v = 8'd22;
            4'd2:  v = 8'd44;
            4'd3:  v = 8'd63;
            4'd4:  v = 8'd82;
            4'd5:  v = 8'd100;
            4'd6:  v = 8'd118;
            4'd7:  v = 8'd134;
            4'd8:  v = 8'd150;
            4'd9:  v = 8'd165;
            4'd10: v = 8'd179;
            4'd11: v = 8'd193;
            4'd12: v = 8'd207;
            4'd13: v = 8'd220;
            4'd14: v = 8'd232;
            4'd15: v = 8'd244;
            default: v = 8'd0;
        endcase
        return v;
    endfunction

    assign re_sq = $signed(PW'(re_i)) * $signed(PW'(re_i));
    assign im_sq = $signed(PW'(im_i)) * $signed(PW'(im_i));

    always_comb begin
        s1_re2_d = $unsigned(re_sq);
        s1_im2_d = $unsigned(im_sq);
        if (avg_sel_i > 4'(AVG_LOG2_MAX)) begin
            s1_n_d = 4'(AVG_LOG2_MAX);
        end else begin
            s1_n_d = avg_sel_i;
        end
        s2_p_d = s1_re2_q + s1_im2_q;
    end

    always_comb begin
        first    = (cnt_q == '0);
        n_eff    = first ? s2_n_q : win_n_q;
        mode_eff = first ? s2_mode_q : win_mode_q;
        last_cnt = (16'd1 << n_eff) - 16'd1;
        last     = (16'(cnt_q) == last_cnt);
        sum      = acc_q + AW'(s2_p_q);
        // a new window never compares against the previous max
        if (first || (AW'(s2_p_q) > acc_q)) begin
            peak = s2_p_q;
        end else begin
            peak = PW'(acc_q);
        end

        cnt_d      = cnt_q;
        acc_d      = acc_q;
        win_n_d    = win_n_q;
        win_mode_d = win_mode_q;
        win_vld_d  = 1'b0;
        win_d      = win_q;
        if (s2_vld_q) begin
            if (first) begin
                win_n_d    = s2_n_q;
                win_mode_d = s2_mode_q;
            end
            if (last) begin
                cnt_d     = '0;
                acc_d     = '0;
                win_vld_d = 1'b1;
                win_d     = mode_eff ? peak : PW'(sum >> n_eff);
            end else begin
                cnt_d = cnt_q + 1'b1;
                acc_d = mode_eff ? AW'(peak) : sum;
            end
        end
    end

    always_comb begin
        k_c = '0;
        for (int i = 0; i < PW; i++) begin
            if (win_q[i]) begin
                k_c = IW'(i);
            end
        end
        f_c = 4'd0;
        for (int j = 0; j < 4; j++) begin
            int idx;
            idx = int'(k_c) - 1 - j;
            if (idx >= 0) begin
                f_c[3-j] = win_q[IW'(idx)];
            end
        end
        frac_c = log_lut(f_c);
        lg_d   = (16'(k_c) << 8) + {8'd0, frac_c};
    end

    always_comb begin
        prod    = 40'(lg_q) * 40'd49321 + 40'd8192;
        db_wide = 24'(prod >> 14);
        if (|db_wide[23:16]) begin
            db_d = 16'hFFFF;
        end else begin
            db_d = db_wide[15:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_vld_q   <= 1'b0;
            s1_re2_q   <= '0;
            s1_im2_q   <= '0;
            s1_n_q     <= '0;
            s1_mode_q  <= 1'b0;
            s2_vld_q   <= 1'b0;
            s2_p_q     <= '0;
            s2_n_q     <= '0;
            s2_mode_q  <= 1'b0;
            cnt_q      <= '0;
            acc_q      <= '0;
            win_n_q    <= '0;
            win_mode_q <= 1'b0;
            win_vld_q  <= 1'b0;
            win_q      <= '0;
            lg_vld_q   <= 1'b0;
            lg_q       <= '0;
            valid_o    <= 1'b0;
            db_o       <= '0;
        end else begin
            s1_vld_q   <= valid_i;
            s1_re2_q   <= s1_re2_d;
            s1_im2_q   <= s1_im2_d;
            s1_n_q     <= s1_n_d;
            s1_mode_q  <= mode_i;
            s2_vld_q   <= s1_vld_q;
            s2_p_q     <= s2_p_d;
            s2_n_q     <= s1_n_q;
            s2_mode_q  <= s1_mode_q;
            cnt_q      <= cnt_d;
            acc_q      <= acc_d;
            win_n_q    <= win_n_d;
            win_mode_q <= win_mode_d;
            win_vld_q  <= win_vld_d;
            win_q      <= win_d;
            lg_vld_q   <= win_vld_q;
            lg_q       <= lg_d;
            valid_o    <= lg_vld_q;
            if (lg_vld_q) begin
                db_o <= db_d;
            end
        end
    end

endmodule

// File: doc/avg_power_db.md
# avg_power_db

Parametrised power-to-dB back end for the receiver data path. It takes signed complex baseband samples (re/im), forms |x|², and reduces a window of 2^n samples to one value, either by mean or by peak hold. It converts that value to 10·log10 in unsigned Q8.8 dB and emits one result per window. It sits directly after the signal chain and replaces the fixed one-sample power and dB stages with a single pipelined block that has selectable averaging and mode.

## Interface
- DW, 18: signed width of re_i/im_i.
- AVG_LOG2_MAX, 4: largest supported window exponent (window = 2^avg_sel, max 16 samples).
- Derived (localparam): PW = 2·DW (power width, unsigned); AW = PW + AVG_LOG2_MAX (accumulator width).

Ports:
- clk  in  1  sole clock.
- rst  in  1  synchronous, active-high reset.
- re_i  in  DW  signed real sample.
- im_i  in  DW  signed imaginary sample.
- valid_i  in  1  sample qualifier; no backpressure, accepted every asserted cycle.
- avg_sel_i  in  4  window exponent n; values > AVG_LOG2_MAX clamp to AVG_LOG2_MAX.
- mode_i  in  1  0 = mean, 1 = peak hold (max |x|² in window).
- db_o  out  16  unsigned Q8.8 dB relative to |x|² = 1 LSB².
- valid_o  out  1  one-cycle strobe, one per completed window.

## Operation
- S1: register re², im² (signed multiply, unsigned result, each ≤ 2^(2DW-2)).
- S2: P = re² + im², PW bits unsigned, no overflow possible.
- S3 window reducer:
  - Counter cnt counts valid S2 samples.
  - On the first sample of a window (cnt = 0), avg_sel_i and mode_i are latched. Changes during a window are ignored until the next window starts.
  - Mean mode: acc accumulates P. At the last sample (cnt = 2^n − 1) the result is (acc + P) >> n, truncated.
  - Peak mode: acc = max(acc, P). The first sample of a window loads P directly.
  - At window end, the reduced value is registered with a win_valid strobe, and cnt and acc clear.
  - n = 0 passes every sample through, so there is one output per input.
- S4 log2 in Q.8:
  - k = index of the leading one of the reduced value R.
  - f = the 4 bits immediately below the leading one, left-justified and zero-padded when k < 4.
  - log2_q8 = k·256 + LUT[f].
  - LUT = 0,22,44,63,82,100,118,134,150,165,179,193,207,220,232,244.
  - R = 0 gives log2_q8 = 0.
- S5 scale: db = (log2_q8·49321 + 8192) >> 14 (49321/2^14 ≈ 10·log10 2). Round half-up, saturate to 0xFFFF; saturation cannot occur for DW ≤ 18.
- The reduced value R = 0 and R = 1 both give db_o = 0.

## Timing
- Reset values: db_o = 0, valid_o = 0, cnt = 0, acc = 0, all pipeline valids 0.
- Latency: if valid_i carries the last sample of a window in cycle t, valid_o asserts in cycle t+5.
- Throughput: one sample per clock, with or without gaps. valid_i low stalls nothing; the pipeline valids simply propagate 0.
- Windows count only accepted samples. There is no timeout, so a partial window holds indefinitely.
- db_o holds its last value between strobes.
- Reset mid-window discards the partial window and all in-flight stages; no valid_o is produced for them. The first post-reset sample starts a new window with the current avg_sel_i and mode_i.
- Back-to-back windows: the last sample of window k and the first sample of window k+1 may arrive on consecutive cycles with no bubble. In peak mode the first sample of the new window must not be compared against the old acc.

## Test plan
- Single sample: avg_sel = 0, re = 16, im = 0 → P = 256. Required: valid_o 5 cycles later with db_o = 6165 (0x1815, 24.08 dB).
- Fractional log: avg_sel = 0, re = 3, im = 0 → P = 9, k = 3, f = 2. Required: db_o = 2444.
- Full scale: re = im = −131072 → P = 2^35. Required: db_o = 26972. Also re = im = 0 → db_o = 0.
- Mean window: avg_sel = 2, mode = 0, four samples re = 16, sent with random valid_i gaps. Required: exactly one valid_o, 5 cycles after the 4th sample, db_o = 6165. Then change avg_sel mid-window and check the change takes effect only on the next window.
- Peak hold: avg_sel = 2, mode = 1, re = 1, 4, 2, 3 (im = 0). Required: db_o = 3083. Immediately follow with a window re = 1, 1, 1, 1 and require db_o = 0, proving no stale max carries over.
- Reset mid-window: avg_sel = 3, feed 5 samples, pulse rst, then feed 8 samples of re = 16. Required: exactly one valid_o, db_o = 6165, and valid_o/db_o = 0 during and right after reset.
